// File: rtl/bit_stream_arbiter.sv
// Round-robin arbiter sharing one serial detector FSM among four bit-stream requesters.
// Optional pre-burst FLUSH cycle (fsm_rst pulse) is enabled by defining BSA_FLUSH_EN.
module bit_stream_arbiter #(
    parameter int PKT_LEN = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] bit_in,
    output logic [3:0] grant,
    output logic       fsm_in,
    output logic       fsm_rst,
    input  logic       fsm_out,
    output logic [3:0] done,
    output logic [3:0] hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        XFER   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(PKT_LEN - 1);

`ifdef BSA_FLUSH_EN
    localparam state_t FIRST_STATE = FLUSH;
`else
    localparam state_t FIRST_STATE = XFER;
`endif

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       acc_q,   acc_d;
    logic [3:0] done_q,  done_d;
    logic [3:0] hit_q,   hit_d;
    logic [2:0] pick_s;

    // Returns {found, index}; search starts just after the last granted index.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign pick_s = rr_pick(req, last_q);

    // State register and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
            acc_q   <= 1'b0;
            done_q  <= 4'b0000;
            hit_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state, grant, counter and accumulator logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 4'b0000;
        hit_d   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (pick_s[2]) begin
                    state_d = FIRST_STATE;
                    grant_d = 4'b0001 << pick_s[1:0];
                    last_d  = pick_s[1:0];
                    cnt_d   = CNT_INIT;
                    acc_d   = 1'b0;
                end else begin
                    grant_d = 4'b0000;
                end
            end
`ifdef BSA_FLUSH_EN
            FLUSH: begin
                state_d = XFER;
                cnt_d   = CNT_INIT;
                acc_d   = 1'b0;
            end
`endif
            XFER: begin
                acc_d = acc_q | fsm_out;
                if (cnt_q == 8'd0) begin
                    state_d = REPORT;
                    done_d  = grant_q;
                    hit_d   = (acc_q | fsm_out) ? grant_q : 4'b0000;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            REPORT: begin
                // Chain straight into the next burst when anyone is waiting.
                if (pick_s[2]) begin
                    state_d = FIRST_STATE;
                    grant_d = 4'b0001 << pick_s[1:0];
                    last_d  = pick_s[1:0];
                    cnt_d   = CNT_INIT;
                    acc_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    acc_d   = acc_q | fsm_out;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // Serial path and flush pulse toward the shared detector.
    always_comb begin
        fsm_in  = 1'b0;
        fsm_rst = 1'b0;
        if (state_q == XFER) begin
            fsm_in = bit_in[last_q];
        end else begin
            fsm_in = 1'b0;
        end
`ifdef BSA_FLUSH_EN
        if (state_q == FLUSH) begin
            fsm_rst = 1'b1;
        end else begin
            fsm_rst = 1'b0;
        end
`endif
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign hit   = hit_q;

endmodule

// File: tb/tb_bit_stream_arbiter.sv
// Directed self-checking bench for bit_stream_arbiter with PKT_LEN=4; adapts to BSA_FLUSH_EN.
module tb_bit_stream_arbiter;

    localparam int P = 4;
`ifdef BSA_FLUSH_EN
    localparam int FL = 1;
`else
    localparam int FL = 0;
`endif
    localparam int B = P + 1 + FL;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] bit_in = 4'b0000;
    logic       fsm_out = 1'b0;
    logic [3:0] grant;
    logic       fsm_in;
    logic       fsm_rst;
    logic [3:0] done;
    logic [3:0] hit;

    int tests_run = 0;
    int tests_failed = 0;

    bit_stream_arbiter #(.PKT_LEN(P)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .bit_in (bit_in),
        .grant  (grant),
        .fsm_in (fsm_in),
        .fsm_rst(fsm_rst),
        .fsm_out(fsm_out),
        .done   (done),
        .hit    (hit)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        bit_in = 4'b0000;
        fsm_out = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b1111;
        bit_in = 4'b1111;
        @(negedge clock);
        #1;
        tests_run++;
        if ({grant, done, hit, fsm_rst, fsm_in} !== 14'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got grant=%b done=%b hit=%b rst=%b in=%b want all zero",
                     grant, done, hit, fsm_rst, fsm_in);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] eg, ed;
        logic er, ei, xfer;
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= B + 1; c++) begin
            @(negedge clock);
            bit_in = (c % 2 == 1) ? 4'b0001 : 4'b1110;
            #1;
            eg   = (c <= B) ? 4'b0001 : 4'b0000;
            ed   = (c == B) ? 4'b0001 : 4'b0000;
            er   = (FL == 1) && (c == 1);
            xfer = (c >= FL + 1) && (c <= FL + P);
            ei   = xfer ? bit_in[0] : 1'b0;
            tests_run += 5;
            if (grant !== eg) begin
                tests_failed++;
                $display("FAIL single_grant c=%0d: got %b want %b", c, grant, eg);
            end
            if (done !== ed) begin
                tests_failed++;
                $display("FAIL single_done c=%0d: got %b want %b", c, done, ed);
            end
            if (fsm_rst !== er) begin
                tests_failed++;
                $display("FAIL single_fsm_rst c=%0d: got %b want %b", c, fsm_rst, er);
            end
            if (fsm_in !== ei) begin
                tests_failed++;
                $display("FAIL single_fsm_in c=%0d: got %b want %b", c, fsm_in, ei);
            end
            if (hit !== 4'b0000) begin
                tests_failed++;
                $display("FAIL single_hit c=%0d: got %b want 0000", c, hit);
            end
            if (c == 1) req = 4'b0000;
        end
    endtask

    task automatic test_hit();
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= B; c++) begin
            @(negedge clock);
            fsm_out = (c == FL + 3);
            if (c == 1) req = 4'b0000;
            #1;
            if (c == B) begin
                tests_run += 2;
                if (done !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL hit1_done: got %b want 0001", done);
                end
                if (hit !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL hit1_hit: got %b want 0001", hit);
                end
            end
        end
        fsm_out = 1'b0;
        req = 4'b0001;
        for (int c = 1; c <= B; c++) begin
            @(negedge clock);
            if (c == 1) req = 4'b0000;
            #1;
            if (c == B) begin
                tests_run += 2;
                if (done !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL hit0_done: got %b want 0001", done);
                end
                if (hit !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL hit0_hit: got %b want 0000", hit);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 5 * B; c++) begin
            @(negedge clock);
            #1;
            if ((c - 1) % B == 0) begin
                tests_run++;
                if (grant !== order[(c - 1) / B]) begin
                    tests_failed++;
                    $display("FAIL contention_grant c=%0d: got %b want %b", c, grant, order[(c - 1) / B]);
                end
            end
            if (c % B == 0) begin
                tests_run++;
                if (done !== order[c / B - 1]) begin
                    tests_failed++;
                    $display("FAIL contention_done c=%0d: got %b want %b", c, done, order[c / B - 1]);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] order [3];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0001;
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 3 * B; c++) begin
            @(negedge clock);
            #1;
            if ((c - 1) % B == 0) begin
                tests_run++;
                if (grant !== order[(c - 1) / B]) begin
                    tests_failed++;
                    $display("FAIL fairness_grant c=%0d: got %b want %b", c, grant, order[(c - 1) / B]);
                end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_early_drop();
        int n_done;
        n_done = 0;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 2 * B; c++) begin
            @(negedge clock);
            if (c == 1) req = 4'b0000;
            #1;
            if (done !== 4'b0000) n_done++;
            if (c == B) begin
                tests_run += 2;
                if (done !== 4'b0100) begin
                    tests_failed++;
                    $display("FAIL drop_done: got %b want 0100", done);
                end
                if (grant !== 4'b0100) begin
                    tests_failed++;
                    $display("FAIL drop_grant_report: got %b want 0100", grant);
                end
            end
            if (c == B + 1) begin
                tests_run++;
                if (grant !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL drop_grant_idle: got %b want 0000", grant);
                end
            end
        end
        tests_run++;
        if (n_done != 1) begin
            tests_failed++;
            $display("FAIL drop_done_count: got %0d want 1", n_done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        bit_in = 4'b1111;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (c == 1) req = 4'b0000;
        end
        #1;
        tests_run += 2;
        if (grant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL midrst_pre_grant: got %b want 0100", grant);
        end
        if (fsm_in !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre_fsm_in: got %b want 1", fsm_in);
        end
        reset = 1'b1;
        #1;
        tests_run += 3;
        if (grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_grant: got %b want 0000", grant);
        end
        if (done !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_done: got %b want 0000", done);
        end
        if (fsm_in !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_fsm_in: got %b want 0", fsm_in);
        end
        @(negedge clock);
        reset = 1'b0;
        req = 4'b1010;
        @(negedge clock);
        #1;
        tests_run++;
        if (grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL midrst_regrant: got %b want 0010", grant);
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_hit();
        test_contention();
        test_fairness();
        test_early_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
